// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: PC link, ROM request/ack bus and decode valid/ready port.
// Macro INSTR_FETCH_DECODE_EN adds the pre-decoded head fields.
interface instr_fetch_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] pc_in;
    logic             pc_inc;
    logic             flush;
    logic             rom_req;
    logic [WIDTH-1:0] rom_addr;
    logic             rom_ack;
    logic [WIDTH-1:0] rom_data;
    logic             instr_valid;
    logic             instr_ready;
    logic [WIDTH-1:0] instr_out;
    logic [WIDTH-1:0] instr_pc;

`ifdef INSTR_FETCH_DECODE_EN
    logic       instr_is_c;
    logic [6:0] instr_comp;
    logic [2:0] instr_dest;
    logic [2:0] instr_jmp;

    modport master (
        input  pc_in, flush, rom_ack, rom_data, instr_ready,
        output pc_inc, rom_req, rom_addr, instr_valid, instr_out, instr_pc,
        output instr_is_c, instr_comp, instr_dest, instr_jmp
    );
    modport slave (
        output pc_in, flush, rom_ack, rom_data, instr_ready,
        input  pc_inc, rom_req, rom_addr, instr_valid, instr_out, instr_pc,
        input  instr_is_c, instr_comp, instr_dest, instr_jmp
    );
`else
    modport master (
        input  pc_in, flush, rom_ack, rom_data, instr_ready,
        output pc_inc, rom_req, rom_addr, instr_valid, instr_out, instr_pc
    );
    modport slave (
        output pc_in, flush, rom_ack, rom_data, instr_ready,
        input  pc_inc, rom_req, rom_addr, instr_valid, instr_out, instr_pc
    );
`endif
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding ROM read, show-ahead FIFO to decode, flush on jump.
// Macro INSTR_FETCH_DECODE_EN adds combinational decode of the FIFO head.
module instr_fetch #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 16
) (
    input logic           clock,
    input logic           reset,
    instr_fetch_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, STEP, DRAIN} state_e;

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] data;
    } entry_t;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    entry_t           head_q, head_d;
    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic             push;
    logic             pop;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bus.flush && count_q < FULL) begin
                    addr_d  = bus.pc_in;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.rom_ack) begin
                    push    = !bus.flush;
                    state_d = bus.flush ? IDLE : STEP;
                end else if (bus.flush) begin
                    state_d = DRAIN;
                end
            end
            STEP:    state_d = IDLE;
            // The stale word is swallowed here; a flush changes nothing further.
            DRAIN:   if (bus.rom_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        pop      = (count_q != '0) && bus.instr_ready && !bus.flush;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = {addr_q, bus.rom_data};
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(push) - CW'(pop);
        end
        // Registered head copy keeps the last word visible once the FIFO drains.
        if (count_d != '0) head_d = mem_d[rd_ptr_d];
    end

    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    // NOTE: storage is not reset; count and pointers alone decide which entries are live.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign bus.rom_req     = (state_q == REQ) || (state_q == DRAIN);
    assign bus.rom_addr    = addr_q;
    assign bus.pc_inc      = (state_q == STEP);
    assign bus.instr_valid = (count_q != '0);
    assign bus.instr_out   = head_q.data;
    assign bus.instr_pc    = head_q.pc;

`ifdef INSTR_FETCH_DECODE_EN
    assign bus.instr_is_c = head_q.data[15];
    assign bus.instr_comp = head_q.data[15] ? head_q.data[12:6] : 7'd0;
    assign bus.instr_dest = head_q.data[15] ? head_q.data[5:3]  : 3'd0;
    assign bus.instr_jmp  = head_q.data[15] ? head_q.data[2:0]  : 3'd0;
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized run,
// checked against a queue-level model of the fetch stream and a PC/ROM environment.
module tb_instr_fetch;
    localparam int DEPTH = 2;
    localparam int WIDTH = 16;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] data;
    } word_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    instr_fetch_if #(.WIDTH(WIDTH)) bus ();
    instr_fetch #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int          n_vec;
    int          n_err;
    int          cyc;
    word_t       q[$];
    word_t       log_q[$];
    logic [15:0] launch_q[$];
    int          push_cyc[$];
    word_t       last_head;
    logic [15:0] pc_reg;
    logic [15:0] prev_addr;
    bit          exp_inc;
    bit          prev_req;
    bit          prev_ack;
    bit          discard;
    bit          stray_ack;
    int          wait_cnt;
    int          ack_delay;
    int          fixed_delay;
    int          size_before;
    int          n_incs;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [15:0] data_of(input logic [15:0] addr);
        return (addr == 16'hFFFF) ? 16'hEC10 : addr + 16'h1000;
    endfunction

    // Called at a falling edge: compares DUT outputs with the model's view.
    task automatic check_outputs();
        word_t exp_head;
        exp_head = (q.size() != 0) ? q[0] : last_head;
        check("instr_valid", 32'(bus.instr_valid), 32'(q.size() != 0));
        check("instr_out", 32'(bus.instr_out), 32'(exp_head.data));
        check("instr_pc", 32'(bus.instr_pc), 32'(exp_head.pc));
        check("pc_inc", 32'(bus.pc_inc), 32'(exp_inc));
        if (prev_req) begin
            if (prev_ack) begin
                check("req_drop", 32'(bus.rom_req), 32'(0));
            end else begin
                check("req_held", 32'(bus.rom_req), 32'(1));
                check("addr_stable", 32'(bus.rom_addr), 32'(prev_addr));
            end
        end else if (bus.rom_req) begin
            check("launch_addr", 32'(bus.rom_addr), 32'(pc_reg));
            check("launch_room", 32'(size_before < DEPTH), 32'(1));
            launch_q.push_back(bus.rom_addr);
            ack_delay = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
            wait_cnt  = 0;
        end
`ifdef INSTR_FETCH_DECODE_EN
        check("dec_is_c", 32'(bus.instr_is_c), 32'(exp_head.data[15]));
        check("dec_comp", 32'(bus.instr_comp), 32'(exp_head.data[15] ? exp_head.data[12:6] : 7'd0));
        check("dec_dest", 32'(bus.instr_dest), 32'(exp_head.data[15] ? exp_head.data[5:3] : 3'd0));
        check("dec_jmp", 32'(bus.instr_jmp), 32'(exp_head.data[15] ? exp_head.data[2:0] : 3'd0));
`endif
        last_head = exp_head;
    endtask

    // One clock: check, drive inputs, advance the model across the rising edge.
    task automatic cycle(input bit fl, input logic [15:0] tgt, input bit rdy);
        bit req;
        bit ack;
        bit push;
        bit pop;
        check_outputs();
        req = bus.rom_req;
        ack = req ? (wait_cnt >= ack_delay) : stray_ack;
        bus.flush       = fl;
        bus.instr_ready = rdy;
        bus.pc_in       = pc_reg;
        bus.rom_ack     = ack;
        bus.rom_data    = (ack && req) ? data_of(bus.rom_addr) : 16'($urandom);
        size_before = q.size();
        push = req && ack && !fl && !discard;
        pop  = (q.size() != 0) && rdy && !fl;
        if (fl) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back({bus.rom_addr, data_of(bus.rom_addr)});
                log_q.push_back({bus.rom_addr, data_of(bus.rom_addr)});
                push_cyc.push_back(cyc);
            end
        end
        if (req && ack) discard = 1'b0;
        else if (req && fl) discard = 1'b1;
        if (req && !ack) wait_cnt++;
        if (bus.pc_inc) n_incs++;
        if (fl) pc_reg = tgt;
        else if (bus.pc_inc) pc_reg = pc_reg + 16'd1;
        exp_inc   = push;
        prev_req  = req;
        prev_ack  = ack;
        prev_addr = bus.rom_addr;
        @(posedge clock);
        @(negedge clock);
        cyc++;
    endtask

    task automatic do_reset(input logic [15:0] start_pc);
        reset           = 1'b0;
        bus.rom_ack     = 1'b1;
        bus.rom_data    = 16'hBEEF;
        bus.flush       = 1'b0;
        bus.instr_ready = 1'b1;
        bus.pc_in       = start_pc;
        repeat (2) begin
            @(posedge clock);
            @(negedge clock);
            cyc++;
            check("rst_req", 32'(bus.rom_req), 32'(0));
            check("rst_inc", 32'(bus.pc_inc), 32'(0));
            check("rst_valid", 32'(bus.instr_valid), 32'(0));
            check("rst_out", 32'(bus.instr_out), 32'(0));
            check("rst_pc", 32'(bus.instr_pc), 32'(0));
            check("rst_addr", 32'(bus.rom_addr), 32'(0));
        end
        reset       = 1'b1;
        q.delete();
        log_q.delete();
        launch_q.delete();
        push_cyc.delete();
        last_head   = '0;
        exp_inc     = 1'b0;
        prev_req    = 1'b0;
        prev_ack    = 1'b0;
        discard     = 1'b0;
        stray_ack   = 1'b0;
        wait_cnt    = 0;
        ack_delay   = 0;
        fixed_delay = 0;
        size_before = 0;
        n_incs      = 0;
        pc_reg      = start_pc;
    endtask

    task automatic run_pushes(input int n, input bit rdy, input int budget);
        int k;
        k = 0;
        while (log_q.size() < n && k < budget) begin
            cycle(1'b0, 16'h0000, rdy);
            k++;
        end
        if (log_q.size() < n) check("push_timeout", 32'(log_q.size()), 32'(n));
    endtask

    task automatic run_until_req(input bit rdy, input int budget);
        int k;
        k = 0;
        while (!bus.rom_req && k < budget) begin
            cycle(1'b0, 16'h0000, rdy);
            k++;
        end
        if (!bus.rom_req) check("req_timeout", 32'(bus.rom_req), 32'(1));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        cyc   = 0;

        // Reset with ack held high, then the first request.
        do_reset(16'h0000);
        cycle(1'b0, 16'h0000, 1'b1);
        check("first_req", 32'(bus.rom_req), 32'(1));
        check("first_addr", 32'(bus.rom_addr), 32'(16'h0000));

        // Streaming with immediate acks.
        run_pushes(4, 1'b1, 40);
        if (log_q.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                check("stream_pc", 32'(log_q[i].pc), 32'(i));
                check("stream_data", 32'(log_q[i].data), 32'(16'h1000 + 16'(i)));
            end
            for (int i = 1; i < 4; i++)
                check("stream_period", 32'(push_cyc[i] - push_cyc[i-1]), 32'(3));
        end
        repeat (2) cycle(1'b0, 16'h0000, 1'b1);
        check("stream_incs", 32'(n_incs), 32'(log_q.size()));

        // Backpressure: full FIFO stalls fetch, one pop resumes it.
        do_reset(16'h0000);
        repeat (20) cycle(1'b0, 16'h0000, 1'b0);
        check("bp_fetches", 32'(log_q.size()), 32'(2));
        check("bp_launches", 32'(launch_q.size()), 32'(2));
        check("bp_incs", 32'(n_incs), 32'(2));
        check("bp_idle_req", 32'(bus.rom_req), 32'(0));
        cycle(1'b0, 16'h0000, 1'b1);
        check("bp_head", 32'(bus.instr_pc), 32'(16'h0001));
        run_pushes(3, 1'b0, 20);
        if (log_q.size() >= 3) check("bp_resume_pc", 32'(log_q[2].pc), 32'(16'h0002));

        // Flush while a slow request is outstanding.
        do_reset(16'h0000);
        fixed_delay = 4;
        cycle(1'b0, 16'h0000, 1'b1);
        cycle(1'b0, 16'h0000, 1'b1);
        cycle(1'b1, 16'h0040, 1'b1);
        check("drain_req_held", 32'(bus.rom_req), 32'(1));
        check("drain_addr", 32'(bus.rom_addr), 32'(16'h0000));
        run_pushes(1, 1'b1, 40);
        check("flush_no_inc", 32'(n_incs), 32'(0));
        if (log_q.size() >= 1) check("flush_target", 32'(log_q[0].pc), 32'(16'h0040));
        if (launch_q.size() >= 2) check("flush_launch", 32'(launch_q[1]), 32'(16'h0040));

        // Flush coincident with ack and pop, one word buffered.
        do_reset(16'h0000);
        run_pushes(1, 1'b0, 20);
        run_until_req(1'b0, 10);
        check("co_valid", 32'(bus.instr_valid), 32'(1));
        cycle(1'b1, 16'h0080, 1'b1);
        check("co_empty", 32'(bus.instr_valid), 32'(0));
        check("co_no_inc", 32'(bus.pc_inc), 32'(0));
        check("co_no_req", 32'(bus.rom_req), 32'(0));
        run_pushes(2, 1'b1, 20);
        if (log_q.size() >= 2) check("co_target", 32'(log_q[1].pc), 32'(16'h0080));
        check("co_incs", 32'(n_incs), 32'(1));

        // Reset in the middle of a request, then a stray ack.
        do_reset(16'h0100);
        fixed_delay = 8;
        cycle(1'b0, 16'h0000, 1'b1);
        cycle(1'b0, 16'h0000, 1'b1);
        check("mid_req", 32'(bus.rom_req), 32'(1));
        do_reset(16'h0200);
        stray_ack = 1'b1;
        cycle(1'b0, 16'h0000, 1'b1);
        stray_ack = 1'b0;
        run_pushes(1, 1'b1, 20);
        if (log_q.size() >= 1) check("mid_next_pc", 32'(log_q[0].pc), 32'(16'h0200));

        // Address wrap and the 16'hEC10 word.
        do_reset(16'hFFFF);
        run_pushes(1, 1'b0, 20);
        check("wrap_head_pc", 32'(bus.instr_pc), 32'(16'hFFFF));
        check("wrap_head_data", 32'(bus.instr_out), 32'(16'hEC10));
`ifdef INSTR_FETCH_DECODE_EN
        check("wrap_is_c", 32'(bus.instr_is_c), 32'(1));
        check("wrap_comp", 32'(bus.instr_comp), 32'(7'b0110000));
        check("wrap_dest", 32'(bus.instr_dest), 32'(3'b010));
        check("wrap_jmp", 32'(bus.instr_jmp), 32'(3'b000));
`endif
        run_pushes(2, 1'b0, 20);
        if (log_q.size() >= 2) check("wrap_next_pc", 32'(log_q[1].pc), 32'(16'h0000));

        // Randomized delays, backpressure and jumps.
        do_reset(16'($urandom));
        fixed_delay = -1;
        for (int i = 0; i < 800; i++) begin
            bit          fl;
            bit          rdy;
            logic [15:0] tgt;
            fl  = ($urandom_range(0, 19) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            tgt = 16'($urandom);
            cycle(fl, tgt, rdy);
        end
        check("rand_progress", 32'(log_q.size() > 50), 32'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
